multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of cycles to wait for mem_ack before faulting (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its posedge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on posedge clk.
REQ-004 SHALL have port opcode, input, 6, instruction[31:26] from the instruction register.
REQ-005 SHALL have port funct, input, 6, instruction[5:0].
REQ-006 SHALL have port zero, input, 1, the ALU zero flag.
REQ-007 SHALL have port mem_ack, input, 1, memory completion for the current mem_req.
REQ-008 SHALL have these outputs, each 1 bit: pc_write, ir_write, reg_write, reg_dst, alu_src, mem_to_reg, mem_req, mem_we, syscall, fault.
REQ-009 SHALL have outputs alu_op, 4, using the ALU_* codes from mips.h; pc_src, 2 (0 = PC+4, 1 = branch target, 2 = jump address); state, 3, the current state code.

Function
REQ-010 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.
REQ-011 SHALL, in FETCH, assert mem_req with mem_we=0; on mem_ack it SHALL pulse ir_write and pc_write with pc_src=0 for one cycle, then go to DECODE.
REQ-012 SHALL, in DECODE, assert no strobes and go to EXEC if the opcode/funct is legal, otherwise go to FAULT.
REQ-013 SHALL accept these instructions: R-type opcode 0x00 with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, syscall 0x0C; lw 0x23; sw 0x2B; beq 0x04; bne 0x05; addi 0x08; j 0x02.
REQ-014 SHALL, in EXEC for R-type arithmetic, drive alu_op from funct with alu_src=0, then go to WB with reg_dst=1 and mem_to_reg=0.
REQ-015 SHALL, in EXEC for addi, lw and sw, drive alu_op=ALU_add with alu_src=1; addi then goes to WB with reg_dst=0, and lw/sw go to MEM.
REQ-016 SHALL, in EXEC for beq and bne, drive alu_op=ALU_sub with alu_src=0 and assert pc_write with pc_src=1 only when zero is true (beq) or false (bne); the next state is FETCH.
REQ-017 SHALL, in EXEC for j, assert pc_write with pc_src=2; the next state is FETCH.
REQ-018 SHALL, in EXEC for syscall, pulse syscall for exactly one cycle; the next state is FETCH.
REQ-019 SHALL, in MEM, hold mem_req high (mem_we=1 for sw) until mem_ack; sw then goes to FETCH and lw to WB with mem_to_reg=1 and reg_dst=0.
REQ-020 SHALL, in WB, assert reg_write for exactly one cycle; the next state is FETCH.
REQ-021 SHALL keep mem_req, mem_we and alu_op stable while waiting for mem_ack; a mem_ack in a non-waiting state SHALL be ignored.
REQ-022 SHALL count wait cycles in FETCH/MEM, reset the count on each state entry, and go to FAULT when the count reaches MEM_TIMEOUT without mem_ack; an ack arriving on the timeout cycle wins.
REQ-023 SHALL, in FAULT, assert fault, deassert every strobe, and stay in FAULT until reset.
REQ-024 SHALL drive all outputs from registered state; the strobes are a combinational decode of state and the registered opcode/funct.
REQ-025 SHALL latch opcode/funct at the end of FETCH.
REQ-026 SHALL take the latencies R/addi 4 cycles, lw 5, sw 4, beq/bne/j/syscall 3 (each with zero wait states), plus the wait cycles.

Reset
REQ-027 SHALL, while rst_n=0 at posedge clk, enter FETCH with the wait counter at 0 and latched opcode/funct at 0.
REQ-028 SHALL drive all strobes to 0, fault to 0 and state to 0 during reset.
REQ-029 SHALL, on reset asserted in any state including mid-wait or FAULT, abandon the operation on the next edge without issuing a strobe.
REQ-030 SHALL assert mem_req in the first cycle after rst_n rises.

Configuration
REQ-031 SHALL, when PERF_COUNTERS_EN is defined, add 32-bit outputs cycle_count (increments every non-reset cycle) and instr_count (increments on each return to FETCH from EXEC, MEM or WB); both wrap at 2^32 and clear on reset.
REQ-032 SHALL, when PERF_COUNTERS_EN is undefined, omit these ports and logic entirely.

Verification
REQ-033 SHALL verify: add (opcode 0x00, funct 0x20) with ack in the same cycle -> states 0,1,2,4,0 and a single reg_write pulse in cycle 4.
REQ-034 SHALL verify: lw (0x23) with mem_ack delayed 3 cycles in MEM -> mem_req held 4 cycles, then WB with mem_to_reg=1.
REQ-035 SHALL verify: beq (0x04) with zero=1 and then zero=0 -> pc_write with pc_src=1 in EXEC only for the zero=1 case.
REQ-036 SHALL verify: opcode 0x3F -> FAULT in the cycle after DECODE, fault=1, and no strobe until reset.
REQ-037 SHALL verify: no mem_ack in FETCH with MEM_TIMEOUT=15 -> FAULT after 15 wait cycles; an ack on cycle 15 yields DECODE instead.
REQ-038 SHALL verify: rst_n=0 during an MEM wait for sw -> no mem_we after the edge, then FETCH; with PERF_COUNTERS_EN, instr_count=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Bundle of signals between the multicycle controller and the datapath/memory.
// master: the controller (drives strobes, samples instruction fields and acks).
// slave:  the datapath/memory side.
interface multicycle_controller_if;
    // Datapath and memory status presented to the controller
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ack;

    // Control outputs
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_req;
    logic       mem_we;
    logic       syscall;
    logic       fault;
    logic [3:0] alu_op;
    logic [1:0] pc_src;
    logic [2:0] state;

    modport master (
        input  opcode, funct, zero, mem_ack,
        output pc_write, ir_write, reg_write, reg_dst, alu_src, mem_to_reg,
               mem_req, mem_we, syscall, fault, alu_op, pc_src, state
    );

    modport slave (
        output opcode, funct, zero, mem_ack,
        input  pc_write, ir_write, reg_write, reg_dst, alu_src, mem_to_reg,
               mem_req, mem_we, syscall, fault, alu_op, pc_src, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Memory accesses in FETCH/MEM wait for mem_ack with a MEM_TIMEOUT watchdog that
// parks the machine in FAULT until reset.
// Optional feature macro: PERF_COUNTERS_EN adds cycle_count / instr_count outputs.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_controller_if.master  bus
`ifdef PERF_COUNTERS_EN
    ,
    output logic [31:0]              cycle_count,
    output logic [31:0]              instr_count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        I_ARITH,
        I_SYSCALL,
        I_LW,
        I_SW,
        I_BEQ,
        I_BNE,
        I_ADDI,
        I_J,
        I_ILLEGAL
    } instr_e;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;

    // Last wait-count value before the watchdog fires
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [5:0] opcode_q, opcode_d;
    logic [5:0] funct_q, funct_d;
    instr_e     instr;
    logic [3:0] arith_op;

    // Classify the latched instruction and pick the R-type ALU operation
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        instr    = I_ILLEGAL;
        arith_op = ALU_ADD;
        case (opcode_q)
            6'h00: begin
                case (funct_q)
                    6'h20: begin instr = I_ARITH; arith_op = ALU_ADD; end
                    6'h22: begin instr = I_ARITH; arith_op = ALU_SUB; end
                    6'h24: begin instr = I_ARITH; arith_op = ALU_AND; end
                    6'h25: begin instr = I_ARITH; arith_op = ALU_OR;  end
                    6'h2A: begin instr = I_ARITH; arith_op = ALU_SLT; end
                    6'h0C: instr = I_SYSCALL;
                    default: instr = I_ILLEGAL;
                endcase
            end
            6'h23:   instr = I_LW;
            6'h2B:   instr = I_SW;
            6'h04:   instr = I_BEQ;
            6'h05:   instr = I_BNE;
            6'h08:   instr = I_ADDI;
            6'h02:   instr = I_J;
            default: instr = I_ILLEGAL;
        endcase
    end

    // Next-state, wait counter and instruction latch
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;          // cleared on every state change
        opcode_d   = opcode_q;
        funct_d    = funct_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ack) begin
                    state_d  = S_DECODE;
                    opcode_d = bus.opcode;
                    funct_d  = bus.funct;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_DECODE: state_d = (instr == I_ILLEGAL) ? S_FAULT : S_EXEC;
            S_EXEC: begin
                case (instr)
                    I_ARITH, I_ADDI: state_d = S_WB;
                    I_LW, I_SW:      state_d = S_MEM;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ack) begin
                    state_d = (instr == I_LW) ? S_WB : S_FETCH;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            opcode_q   <= '0;
            funct_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            opcode_q   <= opcode_d;
            funct_q    <= funct_d;
        end
    end

    // Output decode from state and latched instruction; everything quiet during reset
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.alu_src    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.syscall    = 1'b0;
        bus.fault      = 1'b0;
        bus.alu_op     = ALU_ADD;
        bus.pc_src     = 2'd0;
        bus.state      = S_FETCH;
        if (rst_n) begin
            bus.state = state_q;
            case (state_q)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ack) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 2'd0;
                    end
                end
                S_EXEC: begin
                    case (instr)
                        I_ARITH: begin
                            bus.alu_op  = arith_op;
                            bus.alu_src = 1'b0;
                        end
                        I_ADDI, I_LW, I_SW: begin
                            bus.alu_op  = ALU_ADD;
                            bus.alu_src = 1'b1;
                        end
                        I_BEQ, I_BNE: begin
                            bus.alu_op   = ALU_SUB;
                            bus.alu_src  = 1'b0;
                            bus.pc_src   = 2'd1;
                            bus.pc_write = (instr == I_BEQ) ? bus.zero : ~bus.zero;
                        end
                        I_J: begin
                            bus.pc_write = 1'b1;
                            bus.pc_src   = 2'd2;
                        end
                        I_SYSCALL: bus.syscall = 1'b1;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    // Address computation stays selected for the whole access
                    bus.mem_req = 1'b1;
                    bus.mem_we  = (instr == I_SW);
                    bus.alu_op  = ALU_ADD;
                    bus.alu_src = 1'b1;
                end
                S_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = (instr == I_LW);
                    bus.reg_dst    = (instr == I_ARITH);
                end
                S_FAULT: bus.fault = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef PERF_COUNTERS_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] instr_count_q, instr_count_d;

    // Count active cycles and instructions retiring back to FETCH
    always_comb begin
        cycle_count_d = cycle_count_q + 32'd1;
        instr_count_d = instr_count_q;
        if (state_d == S_FETCH &&
            (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)) begin
            instr_count_d = instr_count_q + 32'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes the expected
// per-cycle control vector, a negedge monitor pops and compares.
module tb_multicycle_controller;

    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;

    // Strobe bit positions: {pc_write, ir_write, reg_write, mem_req, mem_we, syscall, fault}
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_PCW  = 7'b1000000;
    localparam logic [6:0] S_IRW  = 7'b0100000;
    localparam logic [6:0] S_RW   = 7'b0010000;
    localparam logic [6:0] S_MRQ  = 7'b0001000;
    localparam logic [6:0] S_MWE  = 7'b0000100;
    localparam logic [6:0] S_SYS  = 7'b0000010;
    localparam logic [6:0] S_FLT  = 7'b0000001;

    typedef struct {
        string      nm;
        logic [2:0] state;
        logic [6:0] strb;
        logic       chk_alu;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       chk_wb;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       chk_pc;
        logic [1:0] pc_src;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    multicycle_controller_if bus ();

`ifdef PERF_COUNTERS_EN
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
`endif

    multicycle_controller #(.MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef PERF_COUNTERS_EN
        ,
        .cycle_count (cycle_count),
        .instr_count (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t row(input string nm, input logic [2:0] st, input logic [6:0] s);
        exp_t r;
        r.nm = nm; r.state = st; r.strb = s;
        r.chk_alu = 1'b0; r.alu_op = '0; r.alu_src = 1'b0;
        r.chk_wb = 1'b0; r.reg_dst = 1'b0; r.mem_to_reg = 1'b0;
        r.chk_pc = 1'b0; r.pc_src = '0;
        return r;
    endfunction

    function automatic exp_t with_alu(input exp_t r, input logic [3:0] op, input logic src);
        exp_t o;
        o = r; o.chk_alu = 1'b1; o.alu_op = op; o.alu_src = src;
        return o;
    endfunction

    function automatic exp_t with_wb(input exp_t r, input logic rdst, input logic m2r);
        exp_t o;
        o = r; o.chk_wb = 1'b1; o.reg_dst = rdst; o.mem_to_reg = m2r;
        return o;
    endfunction

    function automatic exp_t with_pc(input exp_t r, input logic [1:0] p);
        exp_t o;
        o = r; o.chk_pc = 1'b1; o.pc_src = p;
        return o;
    endfunction

    // FETCH with immediate ack followed by DECODE
    task automatic push_fd(input string nm);
        exp_q.push_back(with_pc(row({nm, " F"}, 3'd0, S_PCW | S_IRW | S_MRQ), 2'd0));
        exp_q.push_back(row({nm, " D"}, 3'd1, S_NONE));
    endtask

    // Apply per-cycle mem_ack / zero / reset-low bits (bit i = cycle i)
    task automatic drive(input int n, input logic [31:0] ack, input logic [31:0] zro,
                         input logic [31:0] rstl);
        for (int i = 0; i < n; i++) begin
            bus.mem_ack = ack[i];
            bus.zero    = zro[i];
            rst_n       = ~rstl[i];
            @(posedge clk);
            #1;
        end
        bus.mem_ack = 1'b0;
        bus.zero    = 1'b0;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        bus.opcode = op;
        bus.funct  = fn;
    endtask

    // Full add instruction with zero wait states
    task automatic run_add(input string nm);
        set_instr(6'h00, 6'h20);
        push_fd(nm);
        exp_q.push_back(with_alu(row({nm, " E"}, 3'd2, S_NONE), ALU_ADD, 1'b0));
        exp_q.push_back(with_wb(row({nm, " W"}, 3'd4, S_RW), 1'b1, 1'b0));
        drive(4, 32'h1, 32'h0, 32'h0);
    endtask

    // Monitor: compare DUT outputs against the head of the scoreboard each cycle
    always @(negedge clk) begin
        exp_t       e;
        logic [6:0] strb;
        logic       ok;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            strb = {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_req,
                    bus.mem_we, bus.syscall, bus.fault};
            ok = (bus.state === e.state) && (strb === e.strb);
            if (e.chk_alu) ok = ok && (bus.alu_op === e.alu_op) && (bus.alu_src === e.alu_src);
            if (e.chk_wb)  ok = ok && (bus.reg_dst === e.reg_dst) && (bus.mem_to_reg === e.mem_to_reg);
            if (e.chk_pc)  ok = ok && (bus.pc_src === e.pc_src);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s: got state=%0d strb=%b alu=%h src=%b rdst=%b m2r=%b pc_src=%0d; want state=%0d strb=%b alu=%h src=%b rdst=%b m2r=%b pc_src=%0d",
                         e.nm, bus.state, strb, bus.alu_op, bus.alu_src, bus.reg_dst,
                         bus.mem_to_reg, bus.pc_src, e.state, e.strb, e.alu_op,
                         e.alu_src, e.reg_dst, e.mem_to_reg, e.pc_src);
            end
        end
    end

    localparam logic [5:0] ARITH_FN  [4] = '{6'h22, 6'h24, 6'h25, 6'h2A};
    localparam logic [3:0] ARITH_ALU [4] = '{ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus.opcode  = '0;
        bus.funct   = '0;
        bus.zero    = 1'b0;
        bus.mem_ack = 1'b0;
        @(posedge clk);
        #1;

        // Reset: state 0, no strobes even with ack asserted
        exp_q.push_back(row("reset0", 3'd0, S_NONE));
        exp_q.push_back(row("reset1", 3'd0, S_NONE));
        drive(2, 32'h3, 32'h0, 32'h3);

        // add: states 0,1,2,4 with one reg_write in cycle 4
        run_add("add");

        // lw with ack delayed 3 cycles in MEM
        set_instr(6'h23, 6'h00);
        push_fd("lw");
        exp_q.push_back(with_alu(row("lw E", 3'd2, S_NONE), ALU_ADD, 1'b1));
        for (int i = 0; i < 4; i++) exp_q.push_back(row("lw M", 3'd3, S_MRQ));
        exp_q.push_back(with_wb(row("lw W", 3'd4, S_RW), 1'b0, 1'b1));
        drive(8, 32'h41, 32'h0, 32'h0);

        // beq taken / not taken
        set_instr(6'h04, 6'h00);
        push_fd("beq z1");
        exp_q.push_back(with_pc(with_alu(row("beq z1 E", 3'd2, S_PCW), ALU_SUB, 1'b0), 2'd1));
        drive(3, 32'h1, 32'h4, 32'h0);
        push_fd("beq z0");
        exp_q.push_back(with_alu(row("beq z0 E", 3'd2, S_NONE), ALU_SUB, 1'b0));
        drive(3, 32'h1, 32'h0, 32'h0);

        // bne taken / not taken
        set_instr(6'h05, 6'h00);
        push_fd("bne z0");
        exp_q.push_back(with_pc(with_alu(row("bne z0 E", 3'd2, S_PCW), ALU_SUB, 1'b0), 2'd1));
        drive(3, 32'h1, 32'h0, 32'h0);
        push_fd("bne z1");
        exp_q.push_back(with_alu(row("bne z1 E", 3'd2, S_NONE), ALU_SUB, 1'b0));
        drive(3, 32'h1, 32'h4, 32'h0);

        // sw with immediate ack in MEM
        set_instr(6'h2B, 6'h00);
        push_fd("sw");
        exp_q.push_back(with_alu(row("sw E", 3'd2, S_NONE), ALU_ADD, 1'b1));
        exp_q.push_back(row("sw M", 3'd3, S_MRQ | S_MWE));
        drive(4, 32'h9, 32'h0, 32'h0);

        // j
        set_instr(6'h02, 6'h00);
        push_fd("j");
        exp_q.push_back(with_pc(row("j E", 3'd2, S_PCW), 2'd2));
        drive(3, 32'h1, 32'h0, 32'h0);

        // syscall
        set_instr(6'h00, 6'h0C);
        push_fd("syscall");
        exp_q.push_back(row("syscall E", 3'd2, S_SYS));
        drive(3, 32'h1, 32'h0, 32'h0);

        // addi, with a stray ack in DECODE that must be ignored
        set_instr(6'h08, 6'h00);
        push_fd("addi");
        exp_q.push_back(with_alu(row("addi E", 3'd2, S_NONE), ALU_ADD, 1'b1));
        exp_q.push_back(with_wb(row("addi W", 3'd4, S_RW), 1'b0, 1'b0));
        drive(4, 32'h3, 32'h0, 32'h0);

        // Remaining R-type arithmetic
        for (int k = 0; k < 4; k++) begin
            set_instr(6'h00, ARITH_FN[k]);
            push_fd("rtype");
            exp_q.push_back(with_alu(row("rtype E", 3'd2, S_NONE), ARITH_ALU[k], 1'b0));
            exp_q.push_back(with_wb(row("rtype W", 3'd4, S_RW), 1'b1, 1'b0));
            drive(4, 32'h1, 32'h0, 32'h0);
        end

        // Ack on the 15th FETCH cycle still wins over the timeout
        set_instr(6'h00, 6'h20);
        for (int i = 0; i < 14; i++) exp_q.push_back(row("ack15 Fwait", 3'd0, S_MRQ));
        push_fd("ack15");
        exp_q.push_back(with_alu(row("ack15 E", 3'd2, S_NONE), ALU_ADD, 1'b0));
        exp_q.push_back(with_wb(row("ack15 W", 3'd4, S_RW), 1'b1, 1'b0));
        drive(18, 32'h4000, 32'h0, 32'h0);

        // Reset during an sw MEM wait: no mem_we after the edge, then FETCH
        set_instr(6'h2B, 6'h00);
        push_fd("swrst");
        exp_q.push_back(with_alu(row("swrst E", 3'd2, S_NONE), ALU_ADD, 1'b1));
        exp_q.push_back(row("swrst M", 3'd3, S_MRQ | S_MWE));
        exp_q.push_back(row("swrst M", 3'd3, S_MRQ | S_MWE));
        exp_q.push_back(row("swrst R", 3'd0, S_NONE));
        exp_q.push_back(row("swrst R", 3'd0, S_NONE));
        drive(7, 32'h1, 32'h0, 32'h60);
`ifdef PERF_COUNTERS_EN
        checks++;
        if (instr_count !== 32'd0 || cycle_count !== 32'd0) begin
            failures++;
            $display("FAIL perf_reset: got instr_count=%0d cycle_count=%0d, want 0 and 0",
                     instr_count, cycle_count);
        end
`endif
        run_add("post swrst");

        // Illegal opcode: FAULT after DECODE, acks ignored, no strobes until reset
        set_instr(6'h3F, 6'h00);
        push_fd("illegal");
        for (int i = 0; i < 3; i++) exp_q.push_back(row("illegal FAULT", 3'd7, S_FLT));
        exp_q.push_back(row("illegal R", 3'd0, S_NONE));
        drive(6, 32'h1D, 32'h0A, 32'h20);
        run_add("post illegal");

        // No ack in FETCH: FAULT after 15 wait cycles
        set_instr(6'h00, 6'h20);
        for (int i = 0; i < 15; i++) exp_q.push_back(row("timeout Fwait", 3'd0, S_MRQ));
        exp_q.push_back(row("timeout FAULT", 3'd7, S_FLT));
        exp_q.push_back(row("timeout FAULT", 3'd7, S_FLT));
        exp_q.push_back(row("timeout R", 3'd0, S_NONE));
        drive(18, 32'h18000, 32'h0, 32'h20000);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d rows left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
